// File: rtl/store_drain_queue_if.sv
// Bundle of commit-side, SRAM-drain-side and load-check signals of the store drain queue.
interface store_drain_queue_if #(
  parameter int PTR_W = 3
);
  logic             commit_store_en;
  logic [31:0]      commit_addr;
  logic [3:0]       commit_sel;
  logic [31:0]      commit_data;
  logic             commit_ready;

  logic             load_req;
  logic             dcache_miss;
  logic             st_sram_en;
  logic [3:0]       st_sram_wen;
  logic [31:0]      st_sram_addr;
  logic [31:0]      st_sram_wdata;

  logic [31:0]      ld_check_addr;
  logic             ld_conflict;

  logic             empty;
  logic [PTR_W:0]   count;
  logic             overflow;

  // The queue itself.
  modport slave (
    input  commit_store_en, commit_addr, commit_sel, commit_data,
    input  load_req, dcache_miss, ld_check_addr,
    output commit_ready, st_sram_en, st_sram_wen, st_sram_addr, st_sram_wdata,
    output ld_conflict, empty, count, overflow
  );

  // Commit stage / AGU / memory side driving the queue.
  modport master (
    output commit_store_en, commit_addr, commit_sel, commit_data,
    output load_req, dcache_miss, ld_check_addr,
    input  commit_ready, st_sram_en, st_sram_wen, st_sram_addr, st_sram_wdata,
    input  ld_conflict, empty, count, overflow
  );
endinterface

// File: rtl/store_drain_queue.sv
// In-order queue of committed stores drained as byte-enabled writes on the
// shared data SRAM port whenever the AGU's loads leave the port idle.

// One queue slot: holds a store and reports whether it covers the load's word.
module sdq_slot (
  input  logic        clk,
  input  logic        resetn,
  input  logic        wr_i,
  input  logic        clr_i,
  input  logic [31:0] wr_addr_i,
  input  logic [3:0]  wr_sel_i,
  input  logic [31:0] wr_data_i,
  input  logic [31:0] chk_addr_i,
  output logic [31:0] addr_o,
  output logic [3:0]  sel_o,
  output logic [31:0] data_o,
  output logic        vld_o,
  output logic        hit_o
);
  logic [31:0] addr_q, addr_d;
  logic [3:0]  sel_q,  sel_d;
  logic [31:0] data_q, data_d;
  logic        vld_q,  vld_d;

  // Next-state: a write fills the slot, a pop clears its valid bit.
  always_comb begin
    addr_d = addr_q;
    sel_d  = sel_q;
    data_d = data_q;
    vld_d  = vld_q;
    if (clr_i) vld_d = 1'b0;
    if (wr_i) begin
      addr_d = wr_addr_i;
      sel_d  = wr_sel_i;
      data_d = wr_data_i;
      vld_d  = 1'b1;
    end
  end

  // Slot registers, cleared by synchronous reset.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      addr_q <= '0;
      sel_q  <= '0;
      data_q <= '0;
      vld_q  <= 1'b0;
    end else begin
      addr_q <= addr_d;
      sel_q  <= sel_d;
      data_q <= data_d;
      vld_q  <= vld_d;
    end
  end

  assign addr_o = addr_q;
  assign sel_o  = sel_q;
  assign data_o = data_q;
  assign vld_o  = vld_q;
  // Word match ignores the byte offset; only registered state participates,
  // so a store being pushed this cycle never flags.
  assign hit_o  = vld_q && (((addr_q ^ chk_addr_i) & ~32'h3) == 32'h0);
endmodule

module store_drain_queue #(
  parameter int DEPTH = 8,
  parameter int PTR_W = 3
) (
  input  logic                clk,
  input  logic                resetn,
  store_drain_queue_if.slave  bus
);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             overflow_q, overflow_d;

  logic [DEPTH-1:0][31:0] slot_addr;
  logic [DEPTH-1:0][3:0]  slot_sel;
  logic [DEPTH-1:0][31:0] slot_data;
  logic [DEPTH-1:0]       slot_vld;
  logic [DEPTH-1:0]       slot_hit;
  logic [DEPTH-1:0]       slot_wr;
  logic [DEPTH-1:0]       slot_clr;

  logic push, pop, drain_en;

  // Readiness comes from the registered count only, so a same-cycle pop
  // never lets a push into a full queue.
  assign bus.commit_ready = (count_q != FULL_CNT);
  assign push             = bus.commit_store_en && bus.commit_ready;
  // Gating with resetn keeps the reset cycle itself free of writes.
  assign drain_en         = resetn && slot_vld[head_q] && !bus.load_req;
  assign pop              = drain_en && !bus.dcache_miss;

  // Decode per-slot write (at tail) and clear (at head) strobes.
  always_comb begin
    slot_wr  = '0;
    slot_clr = '0;
    for (int i = 0; i < DEPTH; i++) begin
      slot_wr[i]  = push && (tail_q == PTR_W'(i));
      slot_clr[i] = pop  && (head_q == PTR_W'(i));
    end
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_slot
    sdq_slot u_slot (
      .clk        (clk),
      .resetn     (resetn),
      .wr_i       (slot_wr[g]),
      .clr_i      (slot_clr[g]),
      .wr_addr_i  (bus.commit_addr),
      .wr_sel_i   (bus.commit_sel),
      .wr_data_i  (bus.commit_data),
      .chk_addr_i (bus.ld_check_addr),
      .addr_o     (slot_addr[g]),
      .sel_o      (slot_sel[g]),
      .data_o     (slot_data[g]),
      .vld_o      (slot_vld[g]),
      .hit_o      (slot_hit[g])
    );
  end

  // Pointer, occupancy and sticky-overflow next state.
  always_comb begin
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    if (push) tail_d = tail_q + PTR_W'(1);
    if (pop)  head_d = head_q + PTR_W'(1);
    if (push && !pop)      count_d = count_q + (PTR_W+1)'(1);
    else if (pop && !push) count_d = count_q - (PTR_W+1)'(1);
    if (bus.commit_store_en && !bus.commit_ready) overflow_d = 1'b1;
  end

  // Control registers, cleared by synchronous reset.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // Drain port: present the head entry, zeros when not requesting.
  always_comb begin
    bus.st_sram_en    = drain_en;
    bus.st_sram_wen   = 4'b0;
    bus.st_sram_addr  = 32'h0;
    bus.st_sram_wdata = 32'h0;
    if (drain_en) begin
      bus.st_sram_wen   = slot_sel[head_q];
      bus.st_sram_addr  = slot_addr[head_q];
      bus.st_sram_wdata = slot_data[head_q];
    end
  end

  assign bus.ld_conflict = |slot_hit;
  assign bus.empty       = (count_q == '0);
  assign bus.count       = count_q;
  assign bus.overflow    = overflow_q;
endmodule

// File: tb/tb_store_drain_queue.sv
// Bench for store_drain_queue: directed scenarios plus random traffic, all
// checked every cycle against a queue-based reference model.
module tb_store_drain_queue;
  localparam int DEPTH = 8;
  localparam int PTR_W = 3;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  store_drain_queue_if #(.PTR_W(PTR_W)) bus();

  store_drain_queue #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  typedef struct {
    logic [31:0] a;
    logic [3:0]  s;
    logic [31:0] d;
  } ment_t;

  ment_t mq[$];
  logic  m_ovf = 1'b0;
  int    n_cmp = 0;
  int    n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive at posedge+1, compare at negedge, advance model at posedge.
  task automatic step(input logic en, input logic [31:0] a, input logic [3:0] s,
                      input logic [31:0] d, input logic lr, input logic miss,
                      input logic [31:0] lca, input logic rn);
    logic        e_en, e_conf, push_ok;
    logic [3:0]  e_wen;
    logic [31:0] e_addr, e_data;
    bus.commit_store_en = en;
    bus.commit_addr     = a;
    bus.commit_sel      = s;
    bus.commit_data     = d;
    bus.load_req        = lr;
    bus.dcache_miss     = miss;
    bus.ld_check_addr   = lca;
    resetn              = rn;
    #4;
    e_en   = rn && (mq.size() > 0) && !lr;
    e_wen  = e_en ? mq[0].s : 4'h0;
    e_addr = e_en ? mq[0].a : 32'h0;
    e_data = e_en ? mq[0].d : 32'h0;
    e_conf = 1'b0;
    foreach (mq[i]) if (mq[i].a[31:2] == lca[31:2]) e_conf = 1'b1;
    chk("st_sram_en",    {31'b0, bus.st_sram_en},  {31'b0, e_en});
    chk("st_sram_wen",   {28'b0, bus.st_sram_wen}, {28'b0, e_wen});
    chk("st_sram_addr",  bus.st_sram_addr,  e_addr);
    chk("st_sram_wdata", bus.st_sram_wdata, e_data);
    chk("commit_ready",  {31'b0, bus.commit_ready}, {31'b0, mq.size() != DEPTH});
    chk("empty",         {31'b0, bus.empty},       {31'b0, mq.size() == 0});
    chk("count",         {28'b0, bus.count},       32'(mq.size()));
    chk("overflow",      {31'b0, bus.overflow},    {31'b0, m_ovf});
    chk("ld_conflict",   {31'b0, bus.ld_conflict}, {31'b0, e_conf});
    @(posedge clk);
    if (!rn) begin
      mq.delete();
      m_ovf = 1'b0;
    end else begin
      push_ok = en && (mq.size() < DEPTH);
      if (en && !push_ok) m_ovf = 1'b1;
      if (e_en && !miss) void'(mq.pop_front());
      if (push_ok) mq.push_back('{a: a, s: s, d: d});
    end
    #1;
  endtask

  task automatic idle(input logic lr, input logic miss, input logic [31:0] lca);
    step(1'b0, 32'h0, 4'h0, 32'h0, lr, miss, lca, 1'b1);
  endtask

  initial begin
    bus.commit_store_en = 1'b0;
    bus.commit_addr     = '0;
    bus.commit_sel      = '0;
    bus.commit_data     = '0;
    bus.load_req        = 1'b0;
    bus.dcache_miss     = 1'b0;
    bus.ld_check_addr   = '0;
    resetn              = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    // Reset state.
    chk("rst_count", {28'b0, bus.count}, 32'h0);
    chk("rst_empty", {31'b0, bus.empty}, 32'h1);
    chk("rst_ready", {31'b0, bus.commit_ready}, 32'h1);
    chk("rst_en",    {31'b0, bus.st_sram_en}, 32'h0);
    idle(1'b0, 1'b0, 32'h0);

    // Basic drain.
    step(1'b1, 32'h100, 4'b0001, 32'h5A5A5A5A, 1'b0, 1'b0, 32'h0, 1'b1);
    chk("basic_en",   {31'b0, bus.st_sram_en}, 32'h1);
    chk("basic_wen",  {28'b0, bus.st_sram_wen}, 32'h1);
    chk("basic_addr", bus.st_sram_addr, 32'h100);
    chk("basic_data", bus.st_sram_wdata, 32'h5A5A5A5A);
    idle(1'b0, 1'b0, 32'h0);
    chk("basic_empty", {31'b0, bus.empty}, 32'h1);
    idle(1'b0, 1'b0, 32'h0);

    // Load priority and dcache stall.
    step(1'b1, 32'h200, 4'b1111, 32'h11111111, 1'b1, 1'b0, 32'h0, 1'b1);
    step(1'b1, 32'h204, 4'b0011, 32'h22222222, 1'b1, 1'b0, 32'h0, 1'b1);
    repeat (3) idle(1'b1, 1'b0, 32'h0);
    repeat (4) idle(1'b0, 1'b1, 32'h0);
    chk("stall_count", {28'b0, bus.count}, 32'h2);
    repeat (3) idle(1'b0, 1'b0, 32'h0);

    // Full and overflow, including a 9th push.
    for (int i = 0; i < 9; i++)
      step(1'b1, 32'h300 + 32'(i*4), 4'(i), 32'hA0 + 32'(i), 1'b1, 1'b0, 32'h0, 1'b1);
    chk("full_ovf",   {31'b0, bus.overflow}, 32'h1);
    chk("full_count", {28'b0, bus.count}, 32'h8);
    repeat (9) idle(1'b0, 1'b0, 32'h0);

    // Streaming push/pop across pointer wrap.
    for (int i = 0; i < 20; i++)
      step(1'b1, 32'h4000 + 32'(i*16), 4'hF, 32'(i), 1'b0, 1'b0, 32'h0, 1'b1);
    chk("stream_count", {28'b0, bus.count}, 32'h1);
    idle(1'b0, 1'b0, 32'h0);

    // Load conflict.
    step(1'b1, 32'h2004, 4'b1100, 32'hCAFE0000, 1'b1, 1'b0, 32'h2006, 1'b1);
    idle(1'b1, 1'b0, 32'h2006);
    idle(1'b1, 1'b0, 32'h2008);
    idle(1'b0, 1'b0, 32'h2006);
    idle(1'b0, 1'b0, 32'h2006);

    // Reset in the middle of a drain.
    for (int i = 0; i < 5; i++)
      step(1'b1, 32'h500 + 32'(i*4), 4'h3, 32'(i), 1'b1, 1'b0, 32'h0, 1'b1);
    step(1'b0, 32'h0, 4'h0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    repeat (2) idle(1'b0, 1'b0, 32'h0);

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      logic [31:0] a, lca;
      a   = 32'h1000 + ($urandom_range(0, 15) << 2) + 32'($urandom_range(0, 3));
      lca = 32'h1000 + ($urandom_range(0, 15) << 2) + 32'($urandom_range(0, 3));
      step($urandom_range(0, 99) < 55, a, 4'($urandom), $urandom,
           $urandom_range(0, 99) < 30, $urandom_range(0, 99) < 25, lca,
           $urandom_range(0, 99) != 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/store_drain_queue.md
Name: store_drain_queue

Overview:
- In-order FIFO of committed stores; the write-side counterpart of the load/store AGU.
- The AGU only produces store address, byte-select and aligned store data into the commit buffer. It never writes data SRAM.
- At retirement the commit stage pushes each store here. This block drains the stores, oldest first, as byte-enabled writes on the shared data SRAM port.
- Loads from the AGU always take priority on that port. The block also flags loads that hit a pending store word.

Parameters:
- DEPTH, 8, number of store entries; power of two, minimum 2.
- PTR_W, 3, log2(DEPTH); width of the head and tail pointers.

Ports:
- clk  in  1  clock.
- resetn  in  1  synchronous active-low reset.
- commit_store_en  in  1  push one committed store this cycle.
- commit_addr  in  32  store vaddr (AGU extra_wdata).
- commit_sel  in  4  byte enables (AGU store_sel).
- commit_data  in  32  lane-replicated store data (AGU wdata).
- commit_ready  out  1  queue not full.
- load_req  in  1  AGU is using the data SRAM port this cycle (its data_sram_en).
- dcache_miss  in  1  memory side stalled; the write issued this cycle is not accepted.
- st_sram_en  out  1  store write request valid.
- st_sram_wen  out  4  byte write enables.
- st_sram_addr  out  32  write address.
- st_sram_wdata  out  32  write data.
- ld_check_addr  in  32  address of the load being issued.
- ld_conflict  out  1  a valid entry matches ld_check_addr word.
- empty  out  1  no valid entries (used for sync/eret drain).
- count  out  PTR_W+1  number of valid entries.
- overflow  out  1  sticky error: a push was attempted while full.

Behaviour:
- Storage:
  - DEPTH entries of {addr, sel, data} plus a per-entry valid bit.
  - head/tail pointers of PTR_W bits that wrap modulo DEPTH.
  - count register, range 0..DEPTH.
- Reset: head=tail=0, count=0, all valid=0, overflow=0. Hence commit_ready=1, empty=1, st_sram_en=0, st_sram_wen=0, st_sram_addr=0, st_sram_wdata=0, ld_conflict=0.
- Reset asserted mid-drain discards all entries. No write is issued in the reset cycle or the cycle after it.
- Push:
  - Condition: commit_store_en && commit_ready.
  - Write the entry at tail, set valid, tail+1.
  - commit_ready = (count != DEPTH). It is combinational from registered count only and does not depend on a same-cycle pop.
  - commit_store_en while full: push ignored, overflow set to 1 and held until reset.
  - commit_sel == 0 is still pushed; it drains with wen=0 and counts as a pop.
- Drain:
  - st_sram_en = valid[head] && !load_req.
  - st_sram_wen = st_sram_en ? sel[head] : 0.
  - addr and data are driven from head when st_sram_en=1, otherwise 0.
  - All drain outputs are combinational from registers plus load_req.
  - Pop when st_sram_en && !dcache_miss: clear valid[head], head+1.
  - While dcache_miss=1, the head and the outputs stay unchanged. Retry continues every cycle until accepted.
- Latency: a store pushed in cycle t can first be presented in cycle t+1. There is no bypass from commit_* to st_sram_*.
- Simultaneous push and pop: both take effect and count is unchanged. This is legal at any count below DEPTH. At count==DEPTH the push is refused even if a pop occurs in the same cycle.
- Wrap: pointers roll DEPTH-1 -> 0. Full/empty is decided by count only, never by pointer equality.
- Ordering: strictly FIFO. No merging, no reordering.
- ld_conflict:
  - OR over all valid entries of (addr[31:2] == ld_check_addr[31:2]). Combinational.
  - The entry popping this cycle still counts.
  - An entry being pushed this cycle does not count.
- empty = (count == 0).

Test Plan:
- Basic drain: reset, push {addr 0x100, sel 4'b0001, data 0x5A5A5A5A} at t with load_req=0 and dcache_miss=0 -> at t+1 st_sram_en=1, wen=0001, addr=0x100, wdata=0x5A5A5A5A; at t+2 empty=1, st_sram_en=0.
- Load priority and stall: two entries queued, load_req=1 for 3 cycles -> st_sram_en=0 and count=2 held. Then load_req=0 with dcache_miss=1 for 4 cycles -> outputs stable on entry0, count=2. Then dcache_miss=0 -> entry0 pops, then entry1 the next cycle.
- Full/overflow: with load_req=1, push 8 stores -> count=8, commit_ready=0. A 9th push -> ignored, overflow=1, count=8. Release load_req -> 8 writes emerge in push order, overflow still 1.
- Simultaneous push/pop plus wrap: stream 20 pushes, one per cycle, while draining one per cycle -> count stays 1 and the addresses on st_sram_addr match push order across pointer wrap.
- Conflict: queue addr 0x2004 sel 1100 -> ld_check_addr 0x2006 gives ld_conflict=1, ld_check_addr 0x2008 gives 0. After that entry pops, 0x2006 gives 0.
- Mid-drain reset: 5 entries queued, assert resetn=0 for one cycle -> count=0, empty=1, no st_sram_en in the following cycles.
